mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline memory stage, directly downstream of the execute stage.
- Consumes execute's registered outputs (opcode, funct3, ALU result, store data, rd info, pc).
- Performs loads and stores over a req/ack data-memory bus: byte-lane steering, write strobes, load sign/zero extension, alignment checking.
- Feeds registered results to writeback and stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width (from header.vh).
- XADDR, 5, register address width.
- OPLEN, 7, opcode width.

Ports:
- i_clk  in  1  CPU clock
- i_rst_n  in  1  synchronous active-low reset
- i_opcode  in  OPLEN  opcode from execute
- i_funct3  in  3  funct3 from execute
- i_alu_result  in  XLEN  ALU result; effective address for L/S
- i_rs2_data  in  XLEN  store data (already forwarded)
- i_rd_addr  in  XADDR  destination register
- i_rd_wr_en  in  1  destination write enable
- i_pc  in  XLEN  instruction pc
- i_stall  in  1  downstream stall
- o_dmem_req  out  1  bus request (registered)
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- o_dmem_wdata  out  XLEN  lane-replicated store data
- o_dmem_wstrb  out  4  byte strobes
- i_dmem_ack  in  1  bus response; single-cycle pulse
- i_dmem_rdata  in  XLEN  read word, valid with ack
- or_opcode  out  OPLEN  to writeback
- or_rd_addr  out  XADDR  to writeback
- or_rd_wr_en  out  1  to writeback
- or_rd_data  out  XLEN  writeback value (ALU result or load data)
- or_pc  out  XLEN  to writeback
- or_misaligned  out  1  one-cycle misaligned-access flag, for future trap logic
- or_misaligned_addr  out  XLEN  offending effective address
- or_stall  out  1  combinational stall to execute and earlier stages

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - All registered outputs, the bus registers and the load buffer clear to 0.
  - State returns to IDLE.
  - Applies in any state; an ack arriving during or after reset is ignored.
- States: IDLE, WAIT, RESP, DONE.
- IDLE, non-memory opcode:
  - If !i_stall: at the next edge, or_* ← inputs, with or_rd_data=i_alu_result. Latency 1 cycle.
  - If i_stall: all or_* hold.
- IDLE, L/S opcode, misaligned:
  - Misaligned means LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - No bus request.
  - At the next edge (if !i_stall): writeback bubble (or_rd_wr_en=0), or_misaligned=1, or_misaligned_addr=addr.
  - State stays IDLE.
- IDLE, aligned L/S, !i_stall:
  - Next edge: o_dmem_req=1, we/addr/wdata/wstrb latched, state→WAIT.
  - or_* are not updated at this edge.
- Store wstrb: SB → 1<<addr[1:0]; SH → 0011 or 1100 by addr[1]; SW → 1111.
- Store wdata: SB replicates byte ×4; SH replicates half ×2; SW passes through.
- WAIT:
  - Bus signals held stable until i_dmem_ack.
  - On ack: req←0, load buffer←i_dmem_rdata, state→RESP.
  - i_stall has no effect in WAIT.
- RESP, when !i_stall: or_* ← instruction fields, state→DONE.
  - Loads: or_rd_data = selected lane, extended.
    - LB/LBU: byte addr[1:0]. LH/LHU: half addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Stores: or_rd_wr_en=0.
- DONE:
  - or_stall=0, so execute advances at this edge.
  - Inputs are ignored (they are the completed instruction).
  - If !i_stall: or_rd_wr_en←0 (bubble) and state→IDLE. If i_stall: hold.
- or_stall = (IDLE & aligned L/S op) | WAIT | RESP | i_stall.
- Aligned load/store occupancy: IDLE→WAIT→(≥0 wait cycles)→RESP→DONE, minimum 4 cycles.
- or_misaligned is high exactly one cycle per offending instruction.
- Unknown funct3 on L/S: treated as LW/SW (alignment rules included).
- Ack outside WAIT: ignored.

Decomposition:
- header.vh gains funct3 constants: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- header.vh gains the state encodings MEM_IDLE/WAIT/RESP/DONE.
- Existing L_OP/S_OP are reused.
- One combinational sub-module: lsu_align. It does wstrb/wdata generation, load extraction/extension and the misaligned check, so it can be unit-tested alone.

Test Plan:
- Non-memory op: opcode I_OP, alu_result=0x1234, rd=5 → next cycle or_rd_data=0x1234, or_rd_wr_en=1, or_stall never asserted.
- LB: addr 0x103, rdata 0x80FF_7F01, ack after 2 wait cycles → or_rd_data=0xFFFFFF80, o_dmem_addr=0x100, or_stall high until DONE.
- LHU: addr 0x202, rdata 0xBEEF_0000 → or_rd_data=0x0000BEEF.
- SB: addr 0x301, rs2=0xAB → wstrb=0010, wdata=0xABABABAB, we=1, or_rd_wr_en=0.
- SW misaligned: addr 0x402 → no o_dmem_req, or_misaligned=1 for one cycle, addr=0x402.
- Reset asserted in WAIT with ack next cycle → req=0 after the reset edge, state IDLE, ack ignored.
- i_stall held in RESP for 3 cycles → or_* unchanged, then load result appears.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory stage: load/store opcodes,
// funct3 encodings, FSM states and the access-size decode helper.
package mem_stage_pkg;

    localparam logic [6:0] L_OP = 7'b0000011;
    localparam logic [6:0] S_OP = 7'b0100011;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2
    } acc_size_t;

    // Unrecognised funct3 values fall back to a full-word access.
    function automatic acc_size_t acc_size(input logic is_store, input logic [2:0] funct3);
        acc_size_t sz;
        sz = ACC_WORD;
        if (is_store) begin
            case (funct3)
                SB:      sz = ACC_BYTE;
                SH:      sz = ACC_HALF;
                SW:      sz = ACC_WORD;
                default: sz = ACC_WORD;
            endcase
        end else begin
            case (funct3)
                LB, LBU: sz = ACC_BYTE;
                LH, LHU: sz = ACC_HALF;
                LW:      sz = ACC_WORD;
                default: sz = ACC_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store strobes/replication, load lane
// extraction with sign/zero extension, and the alignment check.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_word,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data,
    output logic            misaligned
);

    function automatic logic [XLEN-1:0] extend_lane(
        input logic [15:0]     lane,
        input acc_size_t       sz,
        input logic            zext,
        input logic [XLEN-1:0] word
    );
        logic signed [7:0]      b_s;
        logic signed [15:0]     h_s;
        logic signed [XLEN-1:0] sx;
        logic [XLEN-1:0]        r;
        b_s = lane[7:0];
        h_s = lane;
        r   = word;
        if (sz == ACC_BYTE) begin
            if (zext) begin
                r = XLEN'(lane[7:0]);
            end else begin
                sx = XLEN'(b_s);
                r  = sx;
            end
        end else if (sz == ACC_HALF) begin
            if (zext) begin
                r = XLEN'(lane);
            end else begin
                sx = XLEN'(h_s);
                r  = sx;
            end
        end
        return r;
    endfunction

    acc_size_t   sz;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [15:0] sel_lane;

    assign sz        = acc_size(is_store, funct3);
    assign byte_lane = ld_word[{addr_lo, 3'b000} +: 8];
    assign half_lane = ld_word[{addr_lo[1], 4'b0000} +: 16];
    assign sel_lane  = (sz == ACC_BYTE) ? {8'h00, byte_lane} : half_lane;

    always_comb begin
        wstrb      = 4'b0000;
        wdata      = st_data;
        ld_data    = '0;
        misaligned = 1'b0;

        case (sz)
            ACC_WORD: misaligned = (addr_lo != 2'b00);
            ACC_HALF: misaligned = addr_lo[0];
            default:  misaligned = 1'b0;
        endcase
        misaligned = misaligned & (is_load | is_store);

        if (is_store) begin
            case (sz)
                ACC_BYTE: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{st_data[7:0]}};
                end
                ACC_HALF: begin
                    wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{st_data[15:0]}};
                end
                default: begin
                    wstrb = 4'b1111;
                    wdata = st_data;
                end
            endcase
        end

        // funct3[2] distinguishes the unsigned load variants.
        if (is_load) begin
            ld_data = extend_lane(sel_lane, sz, funct3[2], ld_word);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores on a req/ack bus, stalls
// upstream while an access is in flight and registers results for writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int XADDR = 5,
    parameter int OPLEN = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [OPLEN-1:0] i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XADDR-1:0] i_rd_addr,
    input  logic             i_rd_wr_en,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_stall,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic [XLEN-1:0]  o_dmem_addr,
    output logic [XLEN-1:0]  o_dmem_wdata,
    output logic [3:0]       o_dmem_wstrb,
    input  logic             i_dmem_ack,
    input  logic [XLEN-1:0]  i_dmem_rdata,
    output logic [OPLEN-1:0] or_opcode,
    output logic [XADDR-1:0] or_rd_addr,
    output logic             or_rd_wr_en,
    output logic [XLEN-1:0]  or_rd_data,
    output logic [XLEN-1:0]  or_pc,
    output logic             or_misaligned,
    output logic [XLEN-1:0]  or_misaligned_addr,
    output logic             or_stall
);

    mem_state_t state_q, state_d;

    logic             is_ld, is_st, is_mem, idle;
    logic             mem_go;
    logic [OPLEN-1:0] opcode_p1;
    logic [2:0]       funct3_p1;
    logic [XADDR-1:0] rd_addr_p1;
    logic             rd_wr_en_p1;
    logic [XLEN-1:0]  pc_p1;
    logic [XLEN-1:0]  addr_p1;
    logic             is_st_p1;
    logic [XLEN-1:0]  ld_buf_p2;

    logic             lsu_is_load, lsu_is_store;
    logic [2:0]       lsu_funct3;
    logic [1:0]       lsu_addr_lo;
    logic [3:0]       lsu_wstrb;
    logic [XLEN-1:0]  lsu_wdata, lsu_ld_data;
    logic             lsu_misaligned;

    assign is_ld  = (i_opcode == L_OP);
    assign is_st  = (i_opcode == S_OP);
    assign is_mem = is_ld | is_st;
    assign idle   = (state_q == MEM_IDLE);
    assign mem_go = idle & is_mem & ~lsu_misaligned & ~i_stall;

    // The aligner sees the live instruction in IDLE and the captured one afterwards.
    assign lsu_is_load  = idle ? is_ld : ~is_st_p1;
    assign lsu_is_store = idle ? is_st : is_st_p1;
    assign lsu_funct3   = idle ? i_funct3 : funct3_p1;
    assign lsu_addr_lo  = idle ? i_alu_result[1:0] : addr_p1[1:0];

    lsu_align #(
        .XLEN(XLEN)
    ) u_lsu_align (
        .is_load    (lsu_is_load),
        .is_store   (lsu_is_store),
        .funct3     (lsu_funct3),
        .addr_lo    (lsu_addr_lo),
        .st_data    (i_rs2_data),
        .ld_word    (ld_buf_p2),
        .wstrb      (lsu_wstrb),
        .wdata      (lsu_wdata),
        .ld_data    (lsu_ld_data),
        .misaligned (lsu_misaligned)
    );

    assign or_stall = (idle & is_mem & ~lsu_misaligned)
                    | (state_q == MEM_WAIT)
                    | (state_q == MEM_RESP)
                    | i_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (mem_go)      state_d = MEM_WAIT;
            MEM_WAIT: if (i_dmem_ack)  state_d = MEM_RESP;
            MEM_RESP: if (!i_stall)    state_d = MEM_DONE;
            MEM_DONE: if (!i_stall)    state_d = MEM_IDLE;
            default:                   state_d = MEM_IDLE;
        endcase
    end

    // p1: instruction capture at bus issue
    always_ff @(posedge i_clk) begin
        if (mem_go) begin
            opcode_p1   <= i_opcode;
            funct3_p1   <= i_funct3;
            rd_addr_p1  <= i_rd_addr;
            rd_wr_en_p1 <= i_rd_wr_en;
            pc_p1       <= i_pc;
            addr_p1     <= i_alu_result;
            is_st_p1    <= is_st;
        end
    end

    // p2: bus, load buffer and writeback registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_dmem_req         <= 1'b0;
            o_dmem_we          <= 1'b0;
            o_dmem_addr        <= '0;
            o_dmem_wdata       <= '0;
            o_dmem_wstrb       <= 4'b0000;
            ld_buf_p2          <= '0;
            or_opcode          <= '0;
            or_rd_addr         <= '0;
            or_rd_wr_en        <= 1'b0;
            or_rd_data         <= '0;
            or_pc              <= '0;
            or_misaligned      <= 1'b0;
            or_misaligned_addr <= '0;
        end else begin
            or_misaligned <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    if (!i_stall && !is_mem) begin
                        or_opcode   <= i_opcode;
                        or_rd_addr  <= i_rd_addr;
                        or_rd_wr_en <= i_rd_wr_en;
                        or_rd_data  <= i_alu_result;
                        or_pc       <= i_pc;
                    end else if (!i_stall && lsu_misaligned) begin
                        or_opcode          <= i_opcode;
                        or_rd_addr         <= i_rd_addr;
                        or_rd_wr_en        <= 1'b0;
                        or_rd_data         <= i_alu_result;
                        or_pc              <= i_pc;
                        or_misaligned      <= 1'b1;
                        or_misaligned_addr <= i_alu_result;
                    end else if (mem_go) begin
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= is_st;
                        o_dmem_addr  <= {i_alu_result[XLEN-1:2], 2'b00};
                        o_dmem_wdata <= lsu_wdata;
                        o_dmem_wstrb <= lsu_wstrb;
                    end
                end
                MEM_WAIT: begin
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        ld_buf_p2  <= i_dmem_rdata;
                    end
                end
                MEM_RESP: begin
                    if (!i_stall) begin
                        or_opcode   <= opcode_p1;
                        or_rd_addr  <= rd_addr_p1;
                        or_rd_wr_en <= rd_wr_en_p1 & ~is_st_p1;
                        or_rd_data  <= is_st_p1 ? addr_p1 : lsu_ld_data;
                        or_pc       <= pc_p1;
                    end
                end
                MEM_DONE: begin
                    if (!i_stall) begin
                        or_rd_wr_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and queues
// expected bus and writeback traffic; monitors and a bus responder check it.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] R_OP = 7'b0110011;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [6:0]  i_opcode = '0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_alu_result = '0;
    logic [31:0] i_rs2_data = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_rd_wr_en = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_stall = 1'b0;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_wstrb;
    logic [6:0]  or_opcode;
    logic [4:0]  or_rd_addr;
    logic        or_rd_wr_en;
    logic [31:0] or_rd_data, or_pc, or_misaligned_addr;
    logic        or_misaligned, or_stall;

    mem_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
        .i_rd_wr_en(i_rd_wr_en), .i_pc(i_pc), .i_stall(i_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .or_opcode(or_opcode), .or_rd_addr(or_rd_addr), .or_rd_wr_en(or_rd_wr_en),
        .or_rd_data(or_rd_data), .or_pc(or_pc), .or_misaligned(or_misaligned),
        .or_misaligned_addr(or_misaligned_addr), .or_stall(or_stall)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic [31:0] mis_addr;
        logic [31:0] pc;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } resp_t;

    wb_t   wb_q[$];
    bus_t  bus_q[$];
    resp_t resp_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    bit          resp_en = 1'b0;
    bit          in_reset = 1'b1;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: access width in bytes, straight from the ISA rules.
    function automatic int nbytes(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int          nb;
        logic [31:0] mask, v;
        nb = nbytes(1'b0, f3);
        if (nb == 4) return rdata;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = (rdata >> (8 * (addr % 4))) & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] rs2, input int nb);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic [31:0] addr, input int nb);
        logic [7:0] s;
        s = 8'(((1 << nb) - 1) << (addr % 4));
        return s[3:0];
    endfunction

    // mode 0: never stall, 1: random stall, 2: stall three cycles once the bus response is in
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic wen,
                         input int delay, input logic [31:0] rdata, input int mode);
        wb_t         w;
        bus_t        b;
        resp_t       r;
        bit          st, ld, mem, mis, acc;
        int          nb, stall_cnt;
        logic        prev_req;
        logic [31:0] hold_pc;
        st  = (op == S_OP);
        ld  = (op == L_OP);
        mem = st || ld;
        nb  = nbytes(st, f3);
        mis = mem && ((addr % nb) != 0);
        w.op = op; w.rd = rd; w.pc = pc_ctr; w.mis = mis; w.mis_addr = addr;
        if (!mem) begin
            w.wen = wen; w.data = addr; w.chk_data = 1'b1;
        end else if (mis || st) begin
            w.wen = 1'b0; w.data = '0; w.chk_data = 1'b0;
        end else begin
            w.wen = wen; w.data = load_val(f3, addr, rdata); w.chk_data = 1'b1;
        end
        wb_q.push_back(w);
        if (mem && !mis) begin
            b.we = st; b.addr = {addr[31:2], 2'b00};
            b.wdata = exp_wdata(rs2, nb); b.wstrb = exp_wstrb(addr, nb);
            bus_q.push_back(b);
            r.delay = delay; r.rdata = rdata;
            resp_q.push_back(r);
        end
        @(negedge i_clk);
        i_opcode = op; i_funct3 = f3; i_alu_result = addr; i_rs2_data = rs2;
        i_rd_addr = rd; i_rd_wr_en = wen; i_pc = pc_ctr;
        pc_ctr += 32'd4;
        acc = 1'b0; stall_cnt = 0; prev_req = 1'b0; hold_pc = or_pc;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc > 0) @(negedge i_clk);
            #1;
            if (mode == 2 && prev_req && !o_dmem_req) begin
                stall_cnt = 3;
                hold_pc = or_pc;
            end
            prev_req = o_dmem_req;
            if (mode == 1) i_stall = ($urandom_range(0, 3) == 0);
            else           i_stall = (stall_cnt > 0);
            #1;
            if (stall_cnt > 0) begin
                cmp("resp_stall_hold_pc", or_pc, hold_pc);
                cmp("resp_stall_or_stall", 32'(or_stall), 32'd1);
                stall_cnt--;
            end
            if (mode == 0 && cyc == 0 && !(mem && !mis))
                cmp("nonmem_no_stall", 32'(or_stall), 32'd0);
            if (!or_stall) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            miscompares++;
            $display("FAIL issue_timeout: pc %h never accepted, or_stall %b required 0", w.pc, or_stall);
        end
    endtask

    // Writeback monitor: every new or_pc is one retired instruction.
    initial begin
        logic [31:0] last_pc;
        wb_t         w;
        last_pc = '0;
        forever begin
            @(negedge i_clk);
            if (in_reset) begin
                last_pc = or_pc;
            end else if (or_pc !== last_pc) begin
                last_pc = or_pc;
                if (wb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wb_unexpected: writeback pc %h, required none", or_pc);
                end else begin
                    w = wb_q.pop_front();
                    cmp("wb_pc", or_pc, w.pc);
                    cmp("wb_opcode", 32'(or_opcode), 32'(w.op));
                    cmp("wb_rd_addr", 32'(or_rd_addr), 32'(w.rd));
                    cmp("wb_rd_wr_en", 32'(or_rd_wr_en), 32'(w.wen));
                    if (w.chk_data) cmp("wb_rd_data", or_rd_data, w.data);
                    cmp("wb_misaligned", 32'(or_misaligned), 32'(w.mis));
                    if (w.mis) cmp("wb_misaligned_addr", or_misaligned_addr, w.mis_addr);
                end
            end else begin
                cmp("misaligned_single_cycle", 32'(or_misaligned), 32'd0);
            end
        end
    end

    // Bus monitor: checks each new request and that it is held until ack.
    initial begin
        bit          prev;
        bus_t        b;
        logic [31:0] h_addr, h_wdata;
        logic [3:0]  h_wstrb;
        logic        h_we;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_dmem_req === 1'b1 && !prev) begin
                if (bus_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bus_unexpected: request addr %h, required no request", o_dmem_addr);
                end else begin
                    b = bus_q.pop_front();
                    cmp("bus_we", 32'(o_dmem_we), 32'(b.we));
                    cmp("bus_addr", o_dmem_addr, b.addr);
                    if (b.we) begin
                        cmp("bus_wdata", o_dmem_wdata, b.wdata);
                        cmp("bus_wstrb", 32'(o_dmem_wstrb), 32'(b.wstrb));
                    end
                end
                h_addr = o_dmem_addr; h_wdata = o_dmem_wdata; h_wstrb = o_dmem_wstrb; h_we = o_dmem_we;
            end else if (o_dmem_req === 1'b1) begin
                cmp("bus_hold_addr", o_dmem_addr, h_addr);
                cmp("bus_hold_wdata", o_dmem_wdata, h_wdata);
                cmp("bus_hold_ctrl", {27'd0, h_we, h_wstrb}, {27'd0, o_dmem_we, o_dmem_wstrb});
            end
            prev = (o_dmem_req === 1'b1);
        end
    end

    // Bus responder, which also sprinkles stray acks while no request is pending.
    initial begin
        resp_t r;
        forever begin
            @(negedge i_clk);
            if (resp_en && o_dmem_req === 1'b1) begin
                i_dmem_ack = 1'b0;
                if (resp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL resp_unexpected: request with no queued response");
                    r.delay = 0; r.rdata = '0;
                end else begin
                    r = resp_q.pop_front();
                end
                repeat (r.delay) @(negedge i_clk);
                i_dmem_ack = 1'b1;
                i_dmem_rdata = r.rdata;
                @(negedge i_clk);
                i_dmem_ack = 1'b0;
                i_dmem_rdata = $urandom;
            end else if (resp_en) begin
                i_dmem_ack = ($urandom_range(0, 5) == 0);
                i_dmem_rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1);
    end

    initial begin
        logic [31:0] rv_a, rv_b, rv_c, rv_d;
        logic [6:0]  op;
        int          k;

        repeat (3) @(negedge i_clk);
        cmp("reset_req", 32'(o_dmem_req), 32'd0);
        cmp("reset_wstrb", 32'(o_dmem_wstrb), 32'd0);
        cmp("reset_rd_wr_en", 32'(or_rd_wr_en), 32'd0);
        cmp("reset_rd_data", or_rd_data, 32'd0);
        cmp("reset_pc", or_pc, 32'd0);
        cmp("reset_misaligned", 32'(or_misaligned), 32'd0);
        cmp("reset_stall", 32'(or_stall), 32'd0);
        i_rst_n = 1'b1;
        in_reset = 1'b0;

        // Reset while waiting on the bus; the ack that follows must be ignored.
        @(negedge i_clk);
        i_opcode = L_OP; i_funct3 = LW; i_alu_result = 32'h0000_0500; i_pc = '0; i_rd_wr_en = 1'b1;
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_0500, wdata: '0, wstrb: 4'b0000});
        for (int n = 0; n < 10; n++) begin
            @(negedge i_clk);
            if (o_dmem_req) break;
        end
        cmp("rst_wait_req_high", 32'(o_dmem_req), 32'd1);
        i_rst_n = 1'b0;
        i_opcode = '0; i_alu_result = '0; i_rd_wr_en = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'hDEAD_BEEF;
        cmp("rst_req_cleared", 32'(o_dmem_req), 32'd0);
        cmp("rst_stall_cleared", 32'(or_stall), 32'd0);
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        cmp("rst_ack_ignored_req", 32'(o_dmem_req), 32'd0);
        cmp("rst_ack_ignored_stall", 32'(or_stall), 32'd0);
        cmp("rst_ack_ignored_wen", 32'(or_rd_wr_en), 32'd0);
        cmp("rst_ack_ignored_data", or_rd_data, 32'd0);

        resp_en = 1'b1;
        issue(I_OP, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0, 0);
        issue(L_OP, LB,  32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 32'h80FF_7F01, 0);
        issue(L_OP, LHU, 32'h0000_0202, 32'h0, 5'd8, 1'b1, 1, 32'hBEEF_0000, 0);
        issue(S_OP, SB,  32'h0000_0301, 32'h0000_00AB, 5'd9, 1'b1, 0, 32'h0, 0);
        issue(S_OP, SH,  32'h0000_0302, 32'h1234_CDEF, 5'd9, 1'b1, 1, 32'h0, 0);
        issue(S_OP, SW,  32'h0000_0402, 32'h5555_5555, 5'd10, 1'b1, 0, 32'h0, 0);
        issue(L_OP, LH,  32'h0000_0405, 32'h0, 5'd12, 1'b1, 0, 32'h0, 0);
        issue(L_OP, LW,  32'h0000_0600, 32'h0, 5'd11, 1'b1, 1, 32'h1234_5678, 2);
        issue(L_OP, LH,  32'h0000_0702, 32'h0, 5'd13, 1'b1, 0, 32'h8001_7FFF, 2);
        issue(L_OP, 3'b111, 32'h0000_0800, 32'h0, 5'd14, 1'b1, 3, 32'hCAFE_F00D, 0);

        repeat (300) begin
            k = $urandom_range(0, 9);
            op = (k < 4) ? (k[0] ? I_OP : R_OP) : (k < 7) ? L_OP : S_OP;
            rv_a = $urandom; rv_b = $urandom; rv_c = $urandom; rv_d = $urandom;
            if ($urandom_range(0, 1) == 1) rv_a[1:0] = 2'b00;
            issue(op, rv_c[2:0], rv_a, rv_b, rv_c[7:3], rv_c[8], $urandom_range(0, 3), rv_d, 1);
        end

        issue(I_OP, 3'b000, 32'h0000_00AA, 32'h0, 5'd1, 1'b1, 0, 32'h0, 0);
        issue(R_OP, 3'b000, 32'h0000_00BB, 32'h0, 5'd2, 1'b0, 0, 32'h0, 0);
        repeat (6) @(negedge i_clk);
        cmp("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        cmp("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        cmp("resp_queue_drained", 32'(resp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
